// File: rtl/ring_sequencer.sv
// ring_sequencer: N-bit phase sequencer. It runs either as a one-hot ring
// (N states) or as a Johnson/twisted ring (2N states). It supports up/down
// direction, parallel load, a binary phase index, a wrap pulse and
// self-correction of illegal (including unknown) states.
module ring_sequencer #(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          fault
);

  localparam logic [N-1:0]  RING_RST = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  JOHN_RST = {N{1'b0}};
  localparam logic [PW-1:0] RING_LAST = PW'(N - 1);
  localparam logic [PW-1:0] JOHN_LAST = PW'(2*N - 1);

  logic [N-1:0]  q_r;
  logic          mode_r;
  logic          wrap_r;
  logic          fault_r;

  logic          q_legal_s;
  logic          load_legal_s;
  logic [N-1:0]  next_s;
  logic [PW-1:0] phase_s;
  logic [PW-1:0] last_s;
  logic          wrap_cond_s;

  // Reset state for a given mode: bit0 for ring, all zeros for Johnson.
  function automatic logic [N-1:0] rst_state(input logic m);
    if (m) begin
      return JOHN_RST;
    end else begin
      return RING_RST;
    end
  endfunction

  // True when any bit is X or Z. Case inequality catches it in 4-state simulation.
  function automatic logic has_unknown(input logic [N-1:0] v);
    return ((v ^ v) !== {N{1'b0}});
  endfunction

  // Legality for the given mode. Ring: exactly one bit set. Johnson: ones
  // contiguous from the LSB (v+1 is a power of two or zero) or contiguous
  // from the MSB (the same test on ~v).
  function automatic logic is_legal(input logic [N-1:0] v, input logic m);
    logic [N-1:0] inv;
    inv = ~v;
    if (has_unknown(v)) begin
      return 1'b0;
    end else if (m) begin
      return ((v & (v + {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}}) ||
             ((inv & (inv + {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    end else begin
      return (v != {N{1'b0}}) &&
             ((v & (v - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
    end
  endfunction

  // Number of set bits in a known value.
  function automatic int popcount(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        c = c + 1;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Legality of the current state and of the load value, both judged in the registered mode.
  always_comb begin
    q_legal_s    = is_legal(q_r, mode_r);
    load_legal_s = is_legal(load_val, mode_r);
  end

  // Next state for an enabled step, chosen by mode and direction.
  always_comb begin
    next_s = q_r;
    case ({mode_r, dir})
      2'b00:   next_s = {q_r[N-2:0], q_r[N-1]};
      2'b01:   next_s = {q_r[0], q_r[N-1:1]};
      2'b10:   next_s = {q_r[N-2:0], ~q_r[N-1]};
      2'b11:   next_s = {~q_r[0], q_r[N-1:1]};
      default: next_s = q_r;
    endcase
  end

  // Binary phase index from the state; zero while the state is illegal.
  always_comb begin
    phase_s = {PW{1'b0}};
    if (!q_legal_s) begin
      phase_s = {PW{1'b0}};
    end else if (mode_r) begin
      if (q_r[N-1]) begin
        phase_s = PW'(2*N - popcount(q_r));
      end else begin
        phase_s = PW'(popcount(q_r));
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (q_r[i]) begin
          phase_s = PW'(i);
        end else begin
          phase_s = phase_s;
        end
      end
    end
  end

  // Wrap occurs when a step leaves the last phase going up or phase 0 going down.
  always_comb begin
    if (mode_r) begin
      last_s = JOHN_LAST;
    end else begin
      last_s = RING_LAST;
    end
    if (dir) begin
      wrap_cond_s = (phase_s == {PW{1'b0}});
    end else begin
      wrap_cond_s = (phase_s == last_s);
    end
  end

  // State register. Priority: reset > mode change > load > correction > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= rst_state(mode);
      mode_r  <= mode;
      wrap_r  <= 1'b0;
      fault_r <= 1'b0;
    end else if (mode != mode_r) begin
      q_r     <= rst_state(mode);
      mode_r  <= mode;
      wrap_r  <= 1'b0;
      fault_r <= 1'b0;
    end else if (load) begin
      wrap_r <= 1'b0;
      if (load_legal_s) begin
        q_r     <= load_val;
        fault_r <= 1'b0;
      end else begin
        q_r     <= rst_state(mode_r);
        fault_r <= 1'b1;
      end
    end else if (!q_legal_s) begin
      q_r     <= rst_state(mode_r);
      wrap_r  <= 1'b0;
      fault_r <= 1'b1;
    end else if (en) begin
      q_r     <= next_s;
      wrap_r  <= wrap_cond_s;
      fault_r <= 1'b0;
    end else begin
      q_r     <= q_r;
      wrap_r  <= 1'b0;
      fault_r <= 1'b0;
    end
  end

  assign q     = q_r;
  assign phase = phase_s;
  assign wrap  = wrap_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed testbench for ring_sequencer with N=4 and hand-computed expectations.
module tb_ring_sequencer;

  localparam int N  = 4;
  localparam int PW = 3;

  logic          clk;
  logic          reset;
  logic          en;
  logic          mode;
  logic          dir;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  q;
  logic [PW-1:0] phase;
  logic          wrap;
  logic          fault;

  int n_checks;
  int n_fail;

  ring_sequencer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .phase    (phase),
    .wrap     (wrap),
    .fault    (fault)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] ring_q [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] john_q [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = 4'b0000;

    // No reset: the first edge must resolve q to the ring reset state.
    step();
    check("xstart_q", 32'(q), 32'h1);
    check("xstart_fault", 32'(fault), 32'h1);
    step();
    check("xstart_hold_q", 32'(q), 32'h1);
    check("xstart_fault_clear", 32'(fault), 32'h0);

    // Force an illegal value into the state register.
    @(negedge clk);
    force dut.q_r = 4'b1010;
    #1;
    release dut.q_r;
    step();
    check("forced_q", 32'(q), 32'h1);
    check("forced_fault", 32'(fault), 32'h1);

    // Reset into ring mode.
    @(negedge clk);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_q", 32'(q), 32'h1);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // Ring up, four steps, wrap only after the last.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ring_up_q", 32'(q), 32'(ring_q[i]));
      check("ring_up_phase", 32'(phase), 32'((i + 1) % 4));
      check("ring_up_wrap", 32'(wrap), (i == 3) ? 32'h1 : 32'h0);
      check("ring_up_fault", 32'(fault), 32'h0);
    end
    en = 1'b0;

    // Load ring 0100, then switch to Johnson with en high: no step taken.
    load = 1'b1;
    load_val = 4'b0100;
    step();
    load = 1'b0;
    check("ring_load_q", 32'(q), 32'h4);
    mode = 1'b1;
    en = 1'b1;
    step();
    check("mode_chg_q", 32'(q), 32'h0);
    check("mode_chg_phase", 32'(phase), 32'h0);
    check("mode_chg_wrap", 32'(wrap), 32'h0);
    check("mode_chg_fault", 32'(fault), 32'h0);

    // Johnson up, eight steps.
    for (int i = 0; i < 8; i++) begin
      step();
      check("john_up_q", 32'(q), 32'(john_q[i]));
      check("john_up_phase", 32'(phase), 32'((i + 1) % 8));
      check("john_up_wrap", 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
    end
    en = 1'b0;

    // Back to ring, then step down from 0001.
    mode = 1'b0;
    step();
    check("back_ring_q", 32'(q), 32'h1);
    dir = 1'b1;
    en = 1'b1;
    step();
    check("ring_dn_q", 32'(q), 32'h8);
    check("ring_dn_phase", 32'(phase), 32'h3);
    check("ring_dn_wrap", 32'(wrap), 32'h1);
    step();
    check("ring_dn2_q", 32'(q), 32'h4);
    check("ring_dn2_wrap", 32'(wrap), 32'h0);
    en = 1'b0;
    dir = 1'b0;

    // Loads: illegal ring, legal ring, illegal Johnson, legal Johnson.
    load = 1'b1;
    load_val = 4'b0110;
    step();
    check("ring_bad_load_q", 32'(q), 32'h1);
    check("ring_bad_load_fault", 32'(fault), 32'h1);
    load_val = 4'b0100;
    step();
    check("ring_ok_load_q", 32'(q), 32'h4);
    check("ring_ok_load_phase", 32'(phase), 32'h2);
    check("ring_ok_load_fault", 32'(fault), 32'h0);
    load = 1'b0;
    mode = 1'b1;
    step();
    check("to_john_q", 32'(q), 32'h0);
    load = 1'b1;
    load_val = 4'b0101;
    step();
    check("john_bad_load_q", 32'(q), 32'h0);
    check("john_bad_load_fault", 32'(fault), 32'h1);
    load_val = 4'b1100;
    step();
    check("john_ok_load_q", 32'(q), 32'hC);
    check("john_ok_load_phase", 32'(phase), 32'h6);
    check("john_ok_load_wrap", 32'(wrap), 32'h0);
    load_val = 4'b0000;
    step();
    load = 1'b0;

    // Johnson down from 0000 wraps to the last phase.
    dir = 1'b1;
    en = 1'b1;
    step();
    check("john_dn_q", 32'(q), 32'h8);
    check("john_dn_phase", 32'(phase), 32'h7);
    check("john_dn_wrap", 32'(wrap), 32'h1);
    dir = 1'b0;

    // Reset wins over load, en and a mode toggle on the same edge.
    reset = 1'b1;
    load = 1'b1;
    load_val = 4'b1000;
    en = 1'b1;
    mode = 1'b0;
    step();
    check("rst_prio_q", 32'(q), 32'h1);
    check("rst_prio_wrap", 32'(wrap), 32'h0);
    check("rst_prio_fault", 32'(fault), 32'h0);
    reset = 1'b0;
    load = 1'b0;
    en = 1'b0;
    step();
    check("rst_prio_hold_q", 32'(q), 32'h1);
    check("rst_prio_hold_fault", 32'(fault), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
